// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source registers from an external register file,
// forwards in-flight writebacks, and presents a held operand bundle to the consumer.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [3:0]        req_op,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_r_addr1,
  output logic [ADDR_W-1:0] rf_r_addr2,
  input  logic [DATA_W-1:0] rf_r_data1,
  input  logic [DATA_W-1:0] rf_r_data2,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic [3:0]        op_code
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, VALID} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   rf_r_addr1_q, rf_r_addr2_q;
  logic [ADDR_W-1:0]   op_rd_q;
  logic [3:0]          op_code_q;
  logic                fwd1_q, fwd2_q;
  logic [DATA_W-1:0]   fwd_data1_q, fwd_data2_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic                op_valid_q;
  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_w_addr_q;
  logic [DATA_W-1:0]   rf_w_data_q;

  logic                match1, match2;
  logic [DATA_W-1:0]   op_a_d, op_b_d;

  // A write being committed this cycle is invisible to the register file read.
  assign match1 = rf_we_q && (rf_w_addr_q == rf_r_addr1_q);
  assign match2 = rf_we_q && (rf_w_addr_q == rf_r_addr2_q);

  // Newest value wins: live write, then write caught during READ, then the array.
  always_comb begin
    op_a_d = rf_r_data1;
    op_b_d = rf_r_data2;
    if (match1)      op_a_d = rf_w_data_q;
    else if (fwd1_q) op_a_d = fwd_data1_q;
    if (match2)      op_b_d = rf_w_data_q;
    else if (fwd2_q) op_b_d = fwd_data2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_r_addr1_q <= '0;
      rf_r_addr2_q <= '0;
      op_rd_q      <= '0;
      op_code_q    <= '0;
      fwd1_q       <= 1'b0;
      fwd2_q       <= 1'b0;
      fwd_data1_q  <= '0;
      fwd_data2_q  <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rf_r_addr1_q <= req_rs1;
            rf_r_addr2_q <= req_rs2;
            op_rd_q      <= req_rd;
            op_code_q    <= req_op;
            fwd1_q       <= 1'b0;
            fwd2_q       <= 1'b0;
            state_q      <= READ;
          end
        end
        READ: begin
          fwd1_q <= match1;
          fwd2_q <= match2;
          if (match1) fwd_data1_q <= rf_w_data_q;
          if (match2) fwd_data2_q <= rf_w_data_q;
          state_q <= CAPT;
        end
        CAPT: begin
          op_a_q     <= op_a_d;
          op_b_q     <= op_b_d;
          op_valid_q <= 1'b1;
          state_q    <= VALID;
        end
        VALID: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Writeback staging runs every cycle regardless of the fetch state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q     <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
    end else begin
      rf_we_q <= wb_valid;
      if (wb_valid) begin
        rf_w_addr_q <= wb_addr;
        rf_w_data_q <= wb_data;
      end
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign rf_we      = rf_we_q;
  assign rf_w_addr  = rf_w_addr_q;
  assign rf_w_data  = rf_w_data_q;
  assign rf_r_addr1 = rf_r_addr1_q;
  assign rf_r_addr2 = rf_r_addr2_q;
  assign op_valid   = op_valid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_rd      = op_rd_q;
  assign op_code    = op_code_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: external register-file model plus an architectural
// register model updated at commit time, compared against the operand bundle.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_rs1, req_rs2, req_rd;
  logic [3:0]  req_op;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic        rf_we;
  logic [1:0]  rf_w_addr, rf_r_addr1, rf_r_addr2;
  logic [15:0] rf_w_data, rf_r_data1, rf_r_data2;
  logic        op_valid, op_ready;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_rd;
  logic [3:0]  op_code;

  int          cmpCount = 0;
  int          errCount = 0;
  logic [15:0] arch [4];
  logic [15:0] rfMem [4];
  bit          pendValid;
  logic [1:0]  pendAddr;
  logic [15:0] pendData;
  bit          randWb;
  bit          stallWr;
  logic [1:0]  stallWrAddr;
  logic [15:0] stallWrData;

  operand_fetch #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_op(req_op),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_code(op_code)
  );

  always #5 clk = ~clk;

  // Register file with registered read data; a same-edge write is not seen by the read.
  always @(posedge clk) begin
    if (rf_we) rfMem[rf_w_addr] <= rf_w_data;
    rf_r_data1 <= rfMem[rf_r_addr1];
    rf_r_data2 <= rfMem[rf_r_addr2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s differs", tag);
    end
  endtask

  // One clock: a writeback sampled now becomes architecturally visible one edge later.
  task automatic tick();
    if (randWb) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr  = 2'($urandom);
      wb_data  = 16'($urandom);
    end
    @(posedge clk);
    if (pendValid) arch[pendAddr] = pendData;
    pendValid = wb_valid && !rst;
    pendAddr  = wb_addr;
    pendData  = wb_data;
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic wbNext(input logic [1:0] a, input logic [15:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  // Full request: accept, two-cycle fetch, optional consumer stall, release.
  task automatic applyStimulus(input logic [1:0] rs1, input logic [1:0] rs2,
                               input logic [1:0] rd, input logic [3:0] op, input int stall,
                               input bit midWb, input logic [1:0] midAddr,
                               input logic [15:0] midData, input string tag);
    logic [15:0] expA, expB;
    int waitCnt;
    req_valid = 1'b1;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_op = op;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin tick(); waitCnt++; end
    checkOutput({tag, " ready_before"}, req_ready, 1);
    op_ready = (stall == 0);
    tick();
    req_valid = 1'b0;
    req_rs1 = 2'($urandom); req_rs2 = 2'($urandom);
    req_rd = 2'($urandom); req_op = 4'($urandom);
    checkOutput({tag, " ready_read"}, req_ready, 0);
    if (midWb) wbNext(midAddr, midData);
    tick();
    checkOutput({tag, " valid_capt"}, op_valid, 0);
    checkOutput({tag, " ready_capt"}, req_ready, 0);
    tick();
    expA = arch[rs1];
    expB = arch[rs2];
    checkOutput({tag, " valid"}, op_valid, 1);
    checkOutput({tag, " op_a"}, op_a, expA);
    checkOutput({tag, " op_b"}, op_b, expB);
    checkOutput({tag, " op_rd"}, op_rd, rd);
    checkOutput({tag, " op_code"}, op_code, op);
    for (int i = 0; i < stall; i++) begin
      if (stallWr) wbNext(stallWrAddr, stallWrData);
      tick();
      checkOutput({tag, " stall_valid"}, op_valid, 1);
      checkOutput({tag, " stall_a"}, op_a, expA);
      checkOutput({tag, " stall_b"}, op_b, expB);
      checkOutput({tag, " stall_ready"}, req_ready, 0);
    end
    op_ready = 1'b1;
    tick();
    checkOutput({tag, " valid_done"}, op_valid, 0);
    checkOutput({tag, " ready_done"}, req_ready, 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    pendValid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0; req_op = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; op_ready = 1;
    pendValid = 0; randWb = 0; stallWr = 0; stallWrAddr = 0; stallWrData = 0;
    for (int i = 0; i < 4; i++) arch[i] = 16'h0;
    #3;
    checkOutput("rst op_valid", op_valid, 0);
    checkOutput("rst req_ready", req_ready, 0);
    checkOutput("rst rf_we", rf_we, 0);
    checkOutput("rst op_a", op_a, 0);
    checkOutput("rst op_rd", op_rd, 0);
    checkOutput("rst rf_r_addr1", rf_r_addr1, 0);
    checkOutput("rst rf_w_data", rf_w_data, 0);
    doReset();

    // Give every register a known value; R0 is zero.
    wbNext(0, 16'h0000); tick();
    wbNext(1, 16'h1111); tick();
    wbNext(2, 16'h2222); tick();
    wbNext(3, 16'h3333); tick();

    wbNext(2, 16'h1234); tick();
    tick(); tick();
    applyStimulus(2, 2, 1, 4'h3, 0, 0, 0, 0, "same_src");
    checkOutput("same_src model", arch[2], 16'h1234);

    wbNext(1, 16'hBEEF);
    applyStimulus(1, 0, 2, 4'h5, 0, 0, 0, 0, "fwd_accept");

    wbNext(3, 16'h0001);
    applyStimulus(0, 3, 0, 4'h6, 0, 1, 2'd3, 16'h0002, "fwd_newest");
    checkOutput("fwd_newest model", arch[3], 16'h0002);

    stallWr = 1; stallWrAddr = 2; stallWrData = 16'hFFFF;
    applyStimulus(2, 1, 1, 4'h7, 5, 0, 0, 0, "stall");
    stallWr = 0;
    checkOutput("stall late write", arch[2], 16'hFFFF);

    applyStimulus(1, 2, 3, 4'hA, 0, 0, 0, 0, "carry");

    // Reset during CAPT with a write staged toward R0; that write must be lost.
    wbNext(0, 16'h0000); tick(); tick();
    req_valid = 1; req_rs1 = 1; req_rs2 = 2; req_rd = 0; req_op = 4'h1;
    checkOutput("rstcapt ready", req_ready, 1);
    tick();
    req_valid = 0;
    wbNext(0, 16'h5A5A);
    tick();
    checkOutput("rstcapt rf_we_pre", rf_we, 1);
    rst = 1'b1;
    pendValid = 1'b0;
    #1;
    checkOutput("rstcapt op_valid", op_valid, 0);
    checkOutput("rstcapt rf_we", rf_we, 0);
    checkOutput("rstcapt req_ready", req_ready, 0);
    checkOutput("rstcapt rf_w_data", rf_w_data, 0);
    tick(); tick();
    rst = 1'b0;
    applyStimulus(0, 1, 2, 4'h9, 0, 0, 0, 0, "after_rst");
    checkOutput("after_rst R0", arch[0], 16'h0000);

    // Random traffic with writebacks landing in every phase.
    randWb = 1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)), 0, 0, 0, "rand");
    end
    randWb = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
